// File: rtl/soc_timer_axil.sv
// soc_timer_axil: AXI4-Lite timer with 64-bit mtime/mtimecmp, prescaler and level interrupt
module soc_timer_axil #(
    parameter int PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] aw_addr_i,
    input  logic        aw_valid_i,
    output logic        aw_ready_o,
    input  logic [63:0] w_data_i,
    input  logic [7:0]  w_strb_i,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    output logic [1:0]  b_resp_o,
    output logic        b_valid_o,
    input  logic        b_ready_i,
    input  logic [63:0] ar_addr_i,
    input  logic        ar_valid_i,
    output logic        ar_ready_o,
    output logic [63:0] r_data_o,
    output logic [1:0]  r_resp_o,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic        irq_o
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);

    logic [63:0] mtime, mtimecmp, w_q, wdata, wmask, rdata;
    logic [8:0]  aw_q, waddr, raddr;
    logic [7:0]  s_q, wstrb;
    logic [CW-1:0] cnt;
    logic en, ie, pend, aw_held, w_held;
    logic aw_hs, w_hs, ar_hs, commit, wr_mtime, wr_cmp, wr_ctrl, wr_stat, tick, pend_set, pend_clr;
    logic unused;

    assign aw_ready_o = !aw_held && !b_valid_o;
    assign w_ready_o  = !w_held && !b_valid_o;
    assign ar_ready_o = !r_valid_o;
    assign aw_hs  = aw_valid_i && aw_ready_o;
    assign w_hs   = w_valid_i && w_ready_o;
    assign ar_hs  = ar_valid_i && ar_ready_o;
    // a write commits as soon as both halves exist, whether just handshaken or held
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);
    assign waddr  = aw_held ? aw_q : aw_addr_i[11:3];
    assign wdata  = w_held ? w_q : w_data_i;
    assign wstrb  = w_held ? s_q : w_strb_i;
    for (genvar b = 0; b < 8; b++) assign wmask[8*b +: 8] = {8{wstrb[b]}};

    assign wr_mtime = commit && waddr == 9'd0;
    assign wr_cmp   = commit && waddr == 9'd1;
    assign wr_ctrl  = commit && waddr == 9'd2;
    assign wr_stat  = commit && waddr == 9'd3;
    assign tick     = en && cnt == CMAX;
    assign pend_set = en && mtime >= mtimecmp;
    assign pend_clr = wr_stat && wstrb[0] && wdata[0];

    assign raddr = ar_addr_i[11:3];
    assign rdata = raddr == 9'd0 ? mtime :
                   raddr == 9'd1 ? mtimecmp :
                   raddr == 9'd2 ? {62'b0, ie, en} :
                   raddr == 9'd3 ? {63'b0, pend} : 64'b0;
    assign unused = ^{aw_addr_i[63:12], aw_addr_i[2:0], ar_addr_i[63:12], ar_addr_i[2:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime     <= '0;
            mtimecmp  <= '0;
            cnt       <= '0;
            en        <= 1'b0;
            ie        <= 1'b0;
            pend      <= 1'b0;
            irq_o     <= 1'b0;
            aw_held   <= 1'b0;
            aw_q      <= '0;
            w_held    <= 1'b0;
            w_q       <= '0;
            s_q       <= '0;
            b_valid_o <= 1'b0;
            b_resp_o  <= 2'b00;
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_resp_o  <= 2'b00;
        end else begin
            if (wr_mtime && |wstrb) begin
                mtime <= (mtime & ~wmask) | (wdata & wmask);
                cnt   <= '0;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
                cnt   <= '0;
            end else if (en) begin
                cnt <= cnt + CW'(1);
            end
            if (wr_cmp) mtimecmp <= (mtimecmp & ~wmask) | (wdata & wmask);
            if (wr_ctrl && wstrb[0]) {ie, en} <= wdata[1:0];
            pend  <= pend_set || (pend && !pend_clr);
            irq_o <= pend && ie;
            if (commit) aw_held <= 1'b0;
            else if (aw_hs) aw_held <= 1'b1;
            if (aw_hs) aw_q <= aw_addr_i[11:3];
            if (commit) w_held <= 1'b0;
            else if (w_hs) w_held <= 1'b1;
            if (w_hs) begin
                w_q <= w_data_i;
                s_q <= w_strb_i;
            end
            if (commit) begin
                b_valid_o <= 1'b1;
                b_resp_o  <= waddr > 9'd3 ? 2'b10 : 2'b00;
            end else if (b_ready_i) begin
                b_valid_o <= 1'b0;
            end
            if (ar_hs) begin
                r_valid_o <= 1'b1;
                r_data_o  <= rdata;
                r_resp_o  <= raddr > 9'd3 ? 2'b10 : 2'b00;
            end else if (r_ready_i) begin
                r_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_soc_timer_axil.sv
// tb_soc_timer_axil: scoreboard bench; PRESCALE=1 and PRESCALE=4 instances share one bus
`timescale 1ns/1ps
module tb_soc_timer_axil;
    localparam logic [63:0] MTIME = 64'h00, CMP = 64'h08, CTRL = 64'h10, STAT = 64'h18;
    localparam logic [1:0] OK = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [63:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [7:0]  w_strb = '0;
    logic aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid, irq;
    logic [1:0] b_resp, r_resp;
    logic [63:0] r_data;
    logic aw_ready4, w_ready4, b_valid4, ar_ready4, r_valid4, irq4;
    logic [1:0] b_resp4, r_resp4;
    logic [63:0] r_data4, last4;

    int checks = 0, errors = 0;
    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        bit          chk;
    } rexp_t;
    rexp_t rq[$];
    logic [1:0] bq[$];

    soc_timer_axil #(.PRESCALE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .irq_o(irq)
    );

    soc_timer_axil #(.PRESCALE(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready4),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready4),
        .b_resp_o(b_resp4), .b_valid_o(b_valid4), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready4),
        .r_data_o(r_data4), .r_resp_o(r_resp4), .r_valid_o(r_valid4), .r_ready_i(r_ready),
        .irq_o(irq4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] ed, input logic [1:0] er,
                      input bit cd, output logic [63:0] d);
        rexp_t e;
        int n;
        rq.push_back('{ed, er, cd});
        ar_addr = a;
        ar_valid = 1'b1;
        step;
        ar_valid = 1'b0;
        n = 0;
        while (!r_valid && n < 20) begin
            step;
            n++;
        end
        e = rq.pop_front();
        d = r_data;
        last4 = r_data4;
        checks++;
        if (!r_valid) begin
            errors++;
            $display("FAIL rd_timeout addr=%h", a);
        end else begin
            checks++;
            if (r_resp !== e.resp) begin
                errors++;
                $display("FAIL rd_resp addr=%h got=%b exp=%b", a, r_resp, e.resp);
            end
            if (e.chk) begin
                checks++;
                if (r_data !== e.data) begin
                    errors++;
                    $display("FAIL rd_data addr=%h got=%h exp=%h", a, r_data, e.data);
                end
            end
            r_ready = 1'b1;
            step;
            r_ready = 1'b0;
        end
    endtask

    task automatic wait_b;
        logic [1:0] e;
        int n;
        n = 0;
        while (!b_valid && n < 20) begin
            step;
            n++;
        end
        e = bq.pop_front();
        checks++;
        if (!b_valid) begin
            errors++;
            $display("FAIL b_timeout");
        end else if (b_resp !== e) begin
            errors++;
            $display("FAIL b_resp got=%b exp=%b", b_resp, e);
        end
        if (b_valid) begin
            b_ready = 1'b1;
            step;
            b_ready = 1'b0;
        end
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input logic [1:0] er);
        bq.push_back(er);
        aw_addr = a;
        w_data = d;
        w_strb = s;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        step;
        aw_valid = 1'b0;
        w_valid = 1'b0;
        wait_b();
    endtask

    task automatic test_reset;
        logic [63:0] d;
        rst_n = 1'b0;
        step;
        step;
        checks++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, irq, b_resp, r_resp} !== 10'b1110000000 || r_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b b=%b r=%b d=%h exp=111000 00 00 0",
                     aw_ready, w_ready, ar_ready, b_valid, r_valid, irq, b_resp, r_resp, r_data);
        end
        rst_n = 1'b1;
        rd(MTIME, 64'd0, OK, 1, d);
        rd(CMP, 64'd0, OK, 1, d);
        rd(CTRL, 64'd0, OK, 1, d);
        rd(STAT, 64'd0, OK, 1, d);
    endtask

    task automatic test_prescale;
        logic [63:0] d1, d2, a4, b4;
        do_reset;
        wr(CTRL, 64'd1, 8'hFF, OK);
        rd(MTIME, 64'd1, OK, 1, d1);
        a4 = last4;
        checks++;
        if (a4 !== 64'd0) begin
            errors++;
            $display("FAIL ps4_first got=%0d exp=0", a4);
        end
        repeat (10) step;
        rd(MTIME, d1 + 64'd12, OK, 1, d2);
        b4 = last4;
        checks++;
        if (b4 - a4 !== 64'd3) begin
            errors++;
            $display("FAIL ps4_rate got=%0d exp=3", b4 - a4);
        end
    endtask

    task automatic test_irq;
        logic [63:0] d;
        int n;
        do_reset;
        wr(CMP, 64'h20, 8'hFF, OK);
        wr(CTRL, 64'd3, 8'hFF, OK);
        n = 0;
        while (!irq && n < 100) begin
            step;
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL irq_latency got=%0d exp=33", n);
        end
        wr(STAT, 64'd1, 8'hFF, OK);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_reassert got=%b exp=1", irq);
        end
        rd(STAT, 64'd1, OK, 1, d);
        wr(CMP, '1, 8'hFF, OK);
        wr(STAT, 64'd1, 8'hFF, OK);
        step;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
        rd(STAT, 64'd0, OK, 1, d);
    endtask

    task automatic test_handshake;
        logic [63:0] d;
        do_reset;
        bq.push_back(OK);
        w_data = 64'hA5A5_0000_5A5A_1111;
        w_strb = 8'hFF;
        w_valid = 1'b1;
        step;
        w_valid = 1'b0;
        checks++;
        if ({w_ready, aw_ready, b_valid} !== 3'b010) begin
            errors++;
            $display("FAIL w_first_ready got=%b exp=010", {w_ready, aw_ready, b_valid});
        end
        repeat (3) step;
        aw_addr = CMP;
        aw_valid = 1'b1;
        step;
        aw_valid = 1'b0;
        wait_b();
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_single_wfirst got=%b exp=0", b_valid);
        end
        rd(CMP, 64'hA5A5_0000_5A5A_1111, OK, 1, d);
        bq.push_back(OK);
        aw_addr = CMP;
        aw_valid = 1'b1;
        step;
        aw_valid = 1'b0;
        checks++;
        if ({w_ready, aw_ready, b_valid} !== 3'b100) begin
            errors++;
            $display("FAIL aw_first_ready got=%b exp=100", {w_ready, aw_ready, b_valid});
        end
        repeat (2) step;
        w_data = 64'h0123_4567_89AB_CDEF;
        w_valid = 1'b1;
        step;
        w_valid = 1'b0;
        wait_b();
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_single_awfirst got=%b exp=0", b_valid);
        end
        rd(CMP, 64'h0123_4567_89AB_CDEF, OK, 1, d);
        bq.push_back(SLVERR);
        aw_addr = 64'h48;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        step;
        aw_valid = 1'b0;
        w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b11000) begin
                errors++;
                $display("FAIL b_stall cyc=%0d got=%b exp=11000", i, {b_valid, b_resp, aw_ready, w_ready});
            end
            step;
        end
        wait_b();
    endtask

    task automatic test_wrap_strb;
        logic [63:0] d;
        do_reset;
        wr(CTRL, 64'd1, 8'hFF, OK);
        wr(MTIME, '1, 8'hFF, OK);
        rd(MTIME, 64'd0, OK, 1, d);
        wr(CTRL, 64'd0, 8'hFF, OK);
        wr(CMP, 64'd0, 8'hFF, OK);
        wr(CMP, 64'h1122_3344_5566_7788, 8'h0F, OK);
        rd(CMP, 64'h0000_0000_5566_7788, OK, 1, d);
        wr(CMP, '1, 8'h00, OK);
        rd(CMP, 64'h0000_0000_5566_7788, OK, 1, d);
    endtask

    task automatic test_unmapped;
        logic [63:0] d;
        do_reset;
        wr(CMP, 64'h1234, 8'hFF, OK);
        wr(CTRL, 64'd2, 8'hFF, OK);
        wr(64'h40, '1, 8'hFF, SLVERR);
        rd(64'h40, 64'd0, SLVERR, 1, d);
        rd(64'hFF8, 64'd0, SLVERR, 1, d);
        rd(CMP, 64'h1234, OK, 1, d);
        rd(CTRL, 64'd2, OK, 1, d);
        rd(64'h0D, 64'h1234, OK, 1, d);
        rd(64'h1800_0008, 64'h1234, OK, 1, d);
    endtask

    task automatic test_rw_same;
        rexp_t e;
        logic [63:0] d;
        do_reset;
        wr(CMP, 64'h1234, 8'hFF, OK);
        rq.push_back('{64'h1234, OK, 1'b1});
        bq.push_back(OK);
        ar_addr = CMP;
        aw_addr = CMP;
        w_data = 64'h9999;
        w_strb = 8'hFF;
        ar_valid = 1'b1;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        step;
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        w_valid = 1'b0;
        e = rq.pop_front();
        checks++;
        if (r_valid !== 1'b1 || r_data !== e.data) begin
            errors++;
            $display("FAIL rw_same_read got=%b/%h exp=1/%h", r_valid, r_data, e.data);
        end
        r_ready = 1'b1;
        step;
        r_ready = 1'b0;
        wait_b();
        rd(CMP, 64'h9999, OK, 1, d);
    endtask

    task automatic test_reset_mid;
        logic [63:0] d;
        do_reset;
        aw_addr = CMP;
        aw_valid = 1'b1;
        ar_addr = MTIME;
        ar_valid = 1'b1;
        step;
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        checks++;
        if ({r_valid, aw_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_pre got=%b exp=10", {r_valid, aw_ready});
        end
        rst_n = 1'b0;
        step;
        checks++;
        if ({r_valid, aw_ready, ar_ready, b_valid} !== 4'b0110) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=0110", {r_valid, aw_ready, ar_ready, b_valid});
        end
        rst_n = 1'b1;
        w_data = 64'h77;
        w_strb = 8'hFF;
        w_valid = 1'b1;
        step;
        w_valid = 1'b0;
        step;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_aw_discard got=%b exp=0", b_valid);
        end
        do_reset;
        rd(CMP, 64'd0, OK, 1, d);
    endtask

    initial begin
        test_reset;
        test_prescale;
        test_irq;
        test_handshake;
        test_wrap_strb;
        test_unmapped;
        test_rw_same;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/soc_timer_axil.md
# soc_timer_axil

AXI4-Lite responder for the SoC Timer peripheral region (base 0x1800_0000, length 0x1000). Terminates the crossbar's Timer slave port and implements a 64-bit free-running time counter, a 64-bit compare register and a level interrupt toward the PLIC. Decodes only the low 12 address bits; the crossbar has already routed the region.

## Interface
- PRESCALE, 1: clk_i cycles per mtime increment; legal range ≥1.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous reset, active-low.
- aw_addr_i  in  64  write address; aw_valid_i in 1; aw_ready_o out 1.
- w_data_i  in  64  write data; w_strb_i in 8 byte enables; w_valid_i in 1; w_ready_o out 1.
- b_resp_o  out  2  write response (00 OKAY, 10 SLVERR); b_valid_o out 1; b_ready_i in 1.
- ar_addr_i  in  64  read address; ar_valid_i in 1; ar_ready_o out 1.
- r_data_o  out  64  read data; r_resp_o out 2; r_valid_o out 1; r_ready_i in 1.
- irq_o  out  1  timer interrupt, level, registered.

## Operation
- Register map, offset = addr[11:3]×8, addr[2:0] ignored:
  - 0x00 MTIME rw: counter.
  - 0x08 MTIMECMP rw: compare.
  - 0x10 CTRL rw: bit0 EN (count enable), bit1 IE (interrupt enable), other bits read 0.
  - 0x18 STATUS: bit0 PEND, write-1-to-clear; other bits read 0.
  - Offsets 0x20..0xFF8: unmapped → SLVERR, write dropped, read data 0.
- Writes honour w_strb_i per byte; strb=0 is a legal no-op returning OKAY.
- Counting: prescaler cnt runs 0..PRESCALE-1 while EN=1; when cnt==PRESCALE-1, MTIME += 1 (wraps 2^64-1 → 0) and cnt → 0. EN=0 freezes MTIME and cnt.
- An MTIME write zeroes cnt; same-cycle write and increment: write wins (no increment).
- PEND sets at any edge where EN=1 and MTIME ≥ MTIMECMP (unsigned 64-bit, current register values). Sticky; cleared by W1C. Same-cycle set and clear: set wins.
- irq_o = registered (PEND & IE).

## Timing
- Reset values: all registers 0, cnt 0, aw_ready_o/w_ready_o/ar_ready_o 1, b_valid_o/r_valid_o 0, b_resp_o/r_resp_o 00, r_data_o 0, irq_o 0.
- Write channel: AW and W accepted independently into one-entry holding registers. aw_ready_o = !aw_held & !b_valid_o; w_ready_o = !w_held & !b_valid_o.
- At the edge where both address and data are available (either just handshaken or held), the write commits and b_valid_o rises; register visible and b_valid_o high in the next cycle. Holding registers clear at commit.
- b_valid_o holds with stable b_resp_o until b_ready_i; no new AW/W accepted while b_valid_o=1.
- Read channel: ar_ready_o = !r_valid_o. AR handshake at cycle T → r_valid_o, r_data_o, r_resp_o valid at T+1, data = register values at T. Held stable until r_ready_i. Back-to-back reads: one per two cycles minimum.
- Read and write in the same cycle to the same register: read returns pre-write value.
- AXI valids never depend on readys combinationally; all outputs registered except the ready terms above.
- Reset mid-transaction: all pending responses and held AW/W discarded; interface returns to reset values next cycle.

## Test plan
- Reset then read 0x00/0x08/0x10/0x18 → all 0, OKAY; irq_o 0.
- PRESCALE=1: write CTRL=1, wait 10 cycles, read MTIME → value 10±1 consistent with commit cycle; PRESCALE=4 build → increments every 4 cycles.
- MTIMECMP=0x20, CTRL=3 → PEND sets when MTIME reaches 0x20, irq_o high one cycle later; W1C STATUS=1 while MTIME ≥ CMP → PEND re-asserts, irq_o stays high; set CMP=0xFFFF_FFFF_FFFF_FFFF then clear → irq_o low.
- W before AW (3-cycle gap), and AW before W → single B each, OKAY, data correct; b_ready_i held low 5 cycles → b_valid_o stable, aw_ready_o/w_ready_o low throughout.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFF with EN=1 → next increment yields 0; write w_strb=0x0F data 0x1122334455667788 to MTIMECMP → reads 0x0000_0000_5566_7788.
- Read/write offset 0x40 → SLVERR, r_data 0, no register changed; rst_ni low during pending R → r_valid_o 0 next cycle.
